// File: rtl/obi_uart_pkg.sv
// Shared types and defaults for the OBI UART blocks.
// Holds the transmit-arbiter state encoding and its round-robin index helper.
package obi_uart_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned UartArbDefaultTimeout = 1024;

  function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned ofs,
                                          input int unsigned n);
    return (base + ofs) % n;
  endfunction

endpackage

// File: rtl/obi_uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX byte path among NumReq requesters.
// A grant is held until a last byte is accepted or the granted requester idles for TimeoutCycles.
module obi_uart_tx_arbiter
  import obi_uart_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = UartArbDefaultTimeout,
  parameter int unsigned IdxWidth      = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq-1:0][7:0] req_data_i,
  input  logic [NumReq-1:0]      req_last_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic [IdxWidth-1:0]    grant_id_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit          TmoEn = (TimeoutCycles != 0);

  arb_state_e            state_q, state_d;
  logic [IdxWidth-1:0]   grant_q, grant_d;
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic [2*NumReq-1:0]   valid_dbl, valid_shift;
  logic [NumReq-1:0]     valid_rot;
  logic [IdxWidth-1:0]   tz, winner;
  logic                  tz_found;
  logic                  lock, g_valid, g_last, out_free, accept, tmo_hit;

  // Winner pick: rotate so the rr pointer sits at bit 0, find the first set bit, rotate back.
  always_comb begin
    valid_dbl   = {req_valid_i, req_valid_i};
    valid_shift = valid_dbl >> rr_ptr_q;
    valid_rot   = valid_shift[NumReq-1:0];
    tz          = '0;
    tz_found    = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (valid_rot[i] && !tz_found) begin
        tz       = IdxWidth'(i);
        tz_found = 1'b1;
      end
    end
    winner = IdxWidth'(rr_wrap(32'(tz), 32'(rr_ptr_q), NumReq));
  end

  always_comb begin
    lock     = (state_q == ARB_LOCK);
    g_valid  = req_valid_i[grant_q];
    g_last   = req_last_i[grant_q];
    out_free = ~tx_valid_q | tx_ready_i;
    accept   = lock & g_valid & out_free;
    // An accepting cycle is never idle, so a last byte on the threshold cycle always wins.
    tmo_hit  = TmoEn & lock & ~g_valid & (cnt_q == CntW'(TimeoutCycles - 1));

    req_ready_o = '0;
    if (lock) req_ready_o[grant_q] = out_free;

    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    tx_valid_d = tx_ready_i ? 1'b0 : tx_valid_q;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (|req_valid_i) begin
          state_d = ARB_LOCK;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      ARB_LOCK: begin
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = req_data_i[grant_q];
          cnt_d      = '0;
          if (g_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = IdxWidth'(rr_wrap(32'(grant_q), 32'd1, NumReq));
          end
        end else if (tmo_hit) begin
          state_d   = ARB_IDLE;
          rr_ptr_d  = IdxWidth'(rr_wrap(32'(grant_q), 32'd1, NumReq));
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else if (TmoEn && !g_valid) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == ARB_LOCK);
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_obi_uart_tx_arbiter.sv
// Bench for obi_uart_tx_arbiter: directed scenarios plus random traffic against a message-level model.
module tb_obi_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } item_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0][7:0] req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready = 1'b0;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic             timeout;

  always #5 clk = ~clk;

  obi_uart_tx_arbiter #(
    .NumReq       (N),
    .TimeoutCycles(T)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  int checks = 0;
  int errors = 0;

  // Requester-side stimulus: pending bytes per requester and a per-requester valid gate.
  item_t        rq[N][$];
  logic [N-1:0] gate = '1;
  bit           rand_mode = 0;
  int           seen[$];
  int           grants[$];
  int           cyc = 0, tmo_seen = 0, last_tmo_cyc = 0, acc_cyc = 0;
  bit           prev_busy = 0;

  // Reference model: owner of the TX path, round-robin start point, idle run length, 1-deep output.
  bit       m_lock;
  int       m_grant, m_ptr, m_idle;
  bit       m_txv, m_tmo;
  logic [7:0] m_txd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_grant = 0; m_ptr = 0; m_idle = 0;
    m_txv = 0; m_txd = 8'h00; m_tmo = 0;
  endtask

  task automatic push_item(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.d = d;
    it.l = l;
    rq[r].push_back(it);
  endtask

  task automatic drive();
    if (rand_mode) begin
      tx_ready = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < N; i++) begin
        gate[i] = ($urandom_range(0, 99) < 85);
        if (rq[i].size() == 0 && $urandom_range(0, 9) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++)
            push_item(i, 8'($urandom), (j == len - 1) && ($urandom_range(0, 9) != 0));
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = gate[i];
        req_data[i]  = rq[i][0].d;
        req_last[i]  = rq[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'h00;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit free, acc, found;
    int g;
    @(negedge clk);
    free    = !m_txv || tx_ready;
    exp_rdy = '0;
    if (m_lock && free) exp_rdy[m_grant] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (tx_valid && tx_ready) seen.push_back(int'(tx_data));
    g   = m_grant;
    acc = m_lock && req_valid[g] && free;
    m_tmo = 0;
    if (acc) m_txd = req_data[g];
    m_txv = acc ? 1'b1 : (tx_ready ? 1'b0 : m_txv);
    if (!m_lock) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          m_grant = (m_ptr + k) % N;
          found   = 1;
        end
      end
      if (found) begin
        m_lock = 1;
        m_idle = 0;
      end
    end else if (acc) begin
      m_idle = 0;
      if (req_last[g]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % N;
      end
    end else if (!req_valid[g]) begin
      m_idle++;
      if (m_idle == T) begin
        m_lock = 0;
        m_ptr  = (g + 1) % N;
        m_tmo  = 1;
        m_idle = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("tx_valid", 32'(tx_valid), 32'(m_txv));
    check_eq("tx_data", 32'(tx_data), 32'(m_txd));
    check_eq("busy", 32'(busy), 32'(m_lock));
    check_eq("grant_id", 32'(grant_id), 32'(m_grant));
    check_eq("timeout", 32'(timeout), 32'(m_tmo));
    if (timeout) begin
      tmo_seen++;
      last_tmo_cyc = cyc;
    end
    if (busy && !prev_busy) grants.push_back(int'(grant_id));
    prev_busy = busy;
    if (acc) begin
      void'(rq[g].pop_front());
      acc_cyc = cyc;
    end
    drive();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    gate = '1;
    tx_ready = 1'b0;
    drive();
    model_reset();
    prev_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() != 0 || busy || tx_valid)
           && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) check_eq({tag, "_drain_bound"}, 32'(n), 32'(max_cycles - 1));
  endtask

  task automatic wait_empty(input int r, input string tag);
    int n;
    n = 0;
    while (rq[r].size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) check_eq({tag, "_accept_bound"}, 32'(rq[r].size()), 32'd0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int t3_bytes[4]  = '{8'h31, 8'h32, 8'h33, 8'h77};
  int tmo_before, acc_at, n;

  initial begin
    model_reset();
    do_reset();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);

    // Single requester message at full rate.
    seen.delete();
    tx_ready = 1'b1;
    push_item(0, 8'h41, 1'b0);
    push_item(0, 8'h42, 1'b0);
    push_item(0, 8'h0A, 1'b1);
    drive();
    repeat (2) cycle();
    check_eq("t1_first_byte", 32'(tx_data), 32'h41);
    run_until_idle("t1", 20);
    check_eq("t1_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check_eq("t1_b0", 32'(seen[0]), 32'h41);
      check_eq("t1_b1", 32'(seen[1]), 32'h42);
      check_eq("t1_b2", 32'(seen[2]), 32'h0A);
    end
    check_eq("t1_busy_end", 32'(busy), 32'd0);

    // All requesters contending with one-byte messages.
    do_reset();
    grants.delete();
    tx_ready = 1'b1;
    push_item(0, 8'hA0, 1'b1);
    push_item(0, 8'hA4, 1'b1);
    push_item(1, 8'hA1, 1'b1);
    push_item(2, 8'hA2, 1'b1);
    push_item(3, 8'hA3, 1'b1);
    drive();
    run_until_idle("t2", 40);
    check_eq("t2_grants", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      check_eq("t2_order", 32'(grants[i]), 32'(exp_order[i]));

    // Output stall in the middle of a message while another requester waits.
    seen.delete();
    tx_ready = 1'b1;
    push_item(1, 8'h31, 1'b0);
    push_item(1, 8'h32, 1'b0);
    push_item(1, 8'h33, 1'b1);
    drive();
    n = 0;
    while (rq[1].size() != 2 && n < 20) begin
      cycle();
      n++;
    end
    push_item(2, 8'h77, 1'b1);
    tx_ready = 1'b0;
    drive();
    repeat (5) begin
      cycle();
      check_eq("t3_hold_data", 32'(tx_data), 32'h31);
      check_eq("t3_rdy1", 32'(req_ready[1]), 32'd0);
    end
    tx_ready = 1'b1;
    drive();
    run_until_idle("t3", 30);
    check_eq("t3_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check_eq("t3_order", 32'(seen[i]), 32'(t3_bytes[i]));

    // Idle timeout after a message without last.
    do_reset();
    grants.delete();
    tx_ready = 1'b1;
    push_item(3, 8'h55, 1'b0);
    drive();
    wait_empty(3, "t4");
    acc_at = acc_cyc;
    tmo_before = tmo_seen;
    push_item(0, 8'h66, 1'b1);
    drive();
    n = 0;
    while (tmo_seen == tmo_before && n < 30) begin
      cycle();
      n++;
    end
    check_eq("t4_delay", 32'(last_tmo_cyc - acc_at), 32'd8);
    check_eq("t4_busy_fall", 32'(busy), 32'd0);
    run_until_idle("t4", 20);
    check_eq("t4_next_grant", 32'(grants[grants.size()-1]), 32'd0);

    // Last byte on the timeout-threshold cycle.
    tmo_before = tmo_seen;
    push_item(2, 8'h21, 1'b0);
    drive();
    wait_empty(2, "t5");
    push_item(2, 8'h22, 1'b1);
    gate[2] = 1'b0;
    drive();
    repeat (T - 1) cycle();
    gate[2] = 1'b1;
    drive();
    cycle();
    check_eq("t5_accepted", 32'(rq[2].size()), 32'd0);
    run_until_idle("t5", 20);
    check_eq("t5_no_timeout", 32'(tmo_seen - tmo_before), 32'd0);
    check_eq("t5_busy_end", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a message.
    do_reset();
    tx_ready = 1'b0;
    push_item(1, 8'h11, 1'b0);
    push_item(1, 8'h12, 1'b0);
    push_item(1, 8'h13, 1'b1);
    drive();
    repeat (4) cycle();
    check_eq("t6_pre_valid", 32'(tx_valid), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("t6_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("t6_tx_data", 32'(tx_data), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_grant", 32'(grant_id), 32'd0);
    check_eq("t6_timeout", 32'(timeout), 32'd0);
    check_eq("t6_ready", 32'(req_ready), 32'd0);
    do_reset();
    grants.delete();
    tx_ready = 1'b1;
    push_item(3, 8'hC3, 1'b1);
    push_item(2, 8'hC2, 1'b1);
    drive();
    run_until_idle("t6", 20);
    check_eq("t6_first_grant", 32'(grants[0]), 32'd2);

    // Random traffic, including abandoned messages that end by timeout.
    rand_mode = 1;
    drive();
    repeat (3000) cycle();
    rand_mode = 0;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive();
    run_until_idle("rand", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
